// File: rtl/meter_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : meter_defs
// Brief    : Shared FSM encoding and interval counter width for the meter
//            frame sequencer.
// Revision : 1.0
// ============================================================================
package meter_defs;

    localparam int c_interval_w = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/meter_frame_sequencer_cache.sv
`default_nettype none
// ============================================================================
// Module   : meter_channel_cache
// Brief    : One channel's latest indicator array plus a dirty flag that marks
//            it as not yet sent in a frame.
// Revision : 1.0
// ============================================================================
module meter_channel_cache #(
    parameter int indicator_width = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr,
    input  logic [indicator_width-1:0] i_data,
    input  logic                       i_clr,
    output logic [indicator_width-1:0] o_data,
    output logic                       o_dirty
);

    logic [indicator_width-1:0] r_data;
    logic                       r_dirty;

    // A write landing in the same cycle as the load keeps the flag set, so
    // the fresh value is carried by the following frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_dirty <= 1'b0;
        end else begin
            if (i_wr) begin
                r_data  <= i_data;
                r_dirty <= 1'b1;
            end else if (i_clr) begin
                r_dirty <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_dirty = r_dirty;

endmodule
`default_nettype wire

// File: rtl/meter_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : meter_frame_sequencer
// Brief    : Caches per-channel indicator arrays and streams them as rate-
//            limited frames of one beat per channel to a display driver.
// Revision : 1.0
// ============================================================================
module meter_frame_sequencer
    import meter_defs::*;
#(
    parameter int indicator_width = 32,
    parameter int channels        = 2,
    parameter int frame_interval  = 1024
) (
    input  logic                                reset,
    input  logic                                clk,
    input  logic [channels-1:0]                 i_valid,
    output logic [channels-1:0]                 i_ready,
    input  logic [channels*indicator_width-1:0] i_array,
    output logic                                o_valid,
    input  logic                                o_ready,
    output logic [$clog2(channels)-1:0]         o_channel,
    output logic                                o_last,
    output logic [indicator_width-1:0]          o_array
);

    localparam int                      c_idx_w    = $clog2(channels);
    localparam logic [c_idx_w-1:0]      c_last_idx = c_idx_w'(channels - 1);
    localparam logic [c_interval_w-1:0] c_reload   = c_interval_w'(frame_interval - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_interval_w-1:0]    r_count;
    logic                       r_valid;
    logic                       r_last;
    logic [c_idx_w-1:0]         r_channel;
    logic [indicator_width-1:0] r_array;
    logic [channels-1:0]        r_ready;

    logic [indicator_width-1:0] w_cache [channels];
    logic [channels-1:0]        w_dirty;
    logic [channels-1:0]        w_clr;
    logic                       w_accept;
    logic                       w_start;
    logic                       w_load;
    logic [c_idx_w-1:0]         w_load_idx;

    generate
        for (genvar k = 0; k < channels; k++) begin : g_chan
            assign w_clr[k] = w_load && (w_load_idx == c_idx_w'(k));

            meter_channel_cache #(
                .indicator_width (indicator_width)
            ) u_cache (
                .clk     (clk),
                .reset   (reset),
                .i_wr    (i_valid[k]),
                .i_data  (i_array[k*indicator_width +: indicator_width]),
                .i_clr   (w_clr[k]),
                .o_data  (w_cache[k]),
                .o_dirty (w_dirty[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A load selects which cache feeds the output register on this edge:
    // channel 0 at frame start, otherwise the successor of the accepted beat.
    always_comb begin
        w_state_next = r_state;
        w_accept     = r_valid && o_ready;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_load_idx   = '0;
        case (r_state)
            IDLE: begin
                if ((|w_dirty) && (r_count == '0)) begin
                    w_start      = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (w_accept) begin
                    if (r_last) begin
                        w_state_next = IDLE;
                    end else begin
                        w_load     = 1'b1;
                        w_load_idx = r_channel + c_idx_w'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_channel <= '0;
            r_array   <= '0;
            r_count   <= '0;
            r_ready   <= '0;
        end else begin
            r_ready <= '1;
            if (w_load) begin
                r_valid   <= 1'b1;
                r_array   <= w_cache[w_load_idx];
                r_channel <= w_load_idx;
                r_last    <= (w_load_idx == c_last_idx);
            end else if (w_accept && r_last) begin
                r_valid <= 1'b0;
            end
            if (w_start) begin
                r_count <= c_reload;
            end else if (r_count != '0) begin
                r_count <= r_count - c_interval_w'(1);
            end
        end
    end

    assign i_ready   = r_ready;
    assign o_valid   = r_valid;
    assign o_channel = r_channel;
    assign o_last    = r_last;
    assign o_array   = r_array;

endmodule
`default_nettype wire

// File: tb/tb_meter_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_meter_frame_sequencer
// Brief    : Self-checking bench: directed vector table, interval and reset
//            sequences, then random traffic against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_meter_frame_sequencer;

    localparam int CH = 2;
    localparam int W  = 32;
    localparam int FI = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   i_valid;
    logic [CH-1:0]   i_ready;
    logic [CH*W-1:0] i_array;
    logic            o_valid;
    logic            o_ready;
    logic [0:0]      o_channel;
    logic            o_last;
    logic [W-1:0]    o_array;

    int errors = 0;
    int checks = 0;
    int exp_next = 0;
    int starts[$];

    // Reference model: cached arrays, pending flags, rate limiter and beat.
    logic [W-1:0] m_cache [CH];
    logic         m_dirty [CH];
    int           m_count;
    logic         m_valid;
    int           m_ch;
    logic [W-1:0] m_arr;

    typedef struct {
        logic [CH-1:0] iv;
        logic [W-1:0]  a0;
        logic [W-1:0]  a1;
        logic          rdy;
        logic          ev;
        logic [0:0]    ech;
        logic [W-1:0]  earr;
        logic          elast;
    } vec_t;

    vec_t tbl [30];

    always #5 clk = ~clk;

    meter_frame_sequencer #(
        .indicator_width (W),
        .channels        (CH),
        .frame_interval  (FI)
    ) dut (
        .reset     (reset),
        .clk       (clk),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_array   (i_array),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_channel (o_channel),
        .o_last    (o_last),
        .o_array   (o_array)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_cache[k] = '0;
            m_dirty[k] = 1'b0;
        end
        m_count  = 0;
        m_valid  = 1'b0;
        m_ch     = 0;
        m_arr    = '0;
        exp_next = 0;
    endtask

    task automatic model_step(input logic [CH-1:0] iv, input logic [CH*W-1:0] arr, input logic rdy);
        bit any_dirty;
        bit accept;
        int load;
        any_dirty = 1'b0;
        for (int k = 0; k < CH; k++) if (m_dirty[k]) any_dirty = 1'b1;
        accept = m_valid && rdy;
        load   = -1;
        if (!m_valid && any_dirty && m_count == 0) load = 0;
        else if (accept && m_ch < CH - 1)          load = m_ch + 1;
        if (load >= 0) begin
            m_arr         = m_cache[load];
            m_ch          = load;
            m_valid       = 1'b1;
            m_dirty[load] = 1'b0;
        end else if (accept) begin
            m_valid = 1'b0;
        end
        for (int k = 0; k < CH; k++) begin
            if (iv[k]) begin
                m_cache[k] = arr[k*W +: W];
                m_dirty[k] = 1'b1;
            end
        end
        if (load == 0)        m_count = FI - 1;
        else if (m_count > 0) m_count = m_count - 1;
    endtask

    // One clock: drive, check ordering of any beat accepted at this edge,
    // advance to just after the edge and step the model.
    task automatic cycle(input logic [CH-1:0] iv, input logic [CH*W-1:0] arr, input logic rdy);
        i_valid = iv;
        i_array = arr;
        o_ready = rdy;
        if (o_valid && rdy) begin
            check("beat_order", o_channel, exp_next);
            exp_next = (int'(o_channel) == CH - 1) ? 0 : int'(o_channel) + 1;
        end
        @(posedge clk);
        #1;
        model_step(iv, arr, rdy);
    endtask

    task automatic compare(input string tag);
        check({tag, "_valid"}, o_valid, m_valid);
        check({tag, "_ready"}, i_ready, {CH{1'b1}});
        if (m_valid) begin
            check({tag, "_channel"}, o_channel, m_ch);
            check({tag, "_array"}, o_array, m_arr);
            check({tag, "_last"}, o_last, (m_ch == CH - 1));
        end
    endtask

    initial begin
        // iv, a0, a1, rdy | valid, channel, array, last
        tbl[0]  = '{2'b01, 32'h0000FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b1, 1'b0, 32'h0000FFFF, 1'b0};
        tbl[2]  = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1};
        tbl[3]  = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{2'b01, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{2'b00, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0};
        tbl[7]  = '{2'b00, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0};
        tbl[8]  = '{2'b00, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0};
        tbl[9]  = '{2'b00, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0};
        tbl[10] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1};
        tbl[11] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[12] = '{2'b01, 32'hAAAA0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[13] = '{2'b01, 32'h000000FF, 32'h0, 1'b1, 1'b1, 1'b0, 32'hAAAA0000, 1'b0};
        tbl[14] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1};
        tbl[15] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[16] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[17] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b1, 1'b0, 32'h000000FF, 1'b0};
        tbl[18] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1};
        tbl[19] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[20] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[21] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[22] = '{2'b10, 32'h0, 32'hCAFEBABE, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[23] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b1, 1'b0, 32'h000000FF, 1'b0};
        tbl[24] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b1, 1'b1, 32'hCAFEBABE, 1'b1};
        tbl[25] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[26] = '{2'b01, 32'h11111111, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[27] = '{2'b10, 32'h0, 32'h22222222, 1'b1, 1'b1, 1'b0, 32'h11111111, 1'b0};
        tbl[28] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b1, 1'b1, 32'h22222222, 1'b1};
        tbl[29] = '{2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};

        reset   = 1'b1;
        i_valid = '0;
        i_array = '0;
        o_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid",   o_valid,   1'b0);
        check("reset_channel", o_channel, 1'b0);
        check("reset_last",    o_last,    1'b0);
        check("reset_array",   o_array,   32'h0);
        check("reset_ready",   i_ready,   2'b00);
        reset = 1'b0;

        // Directed table: basic frame, backpressure, collision, clean channels.
        for (int r = 0; r < 30; r++) begin
            cycle(tbl[r].iv, {tbl[r].a1, tbl[r].a0}, tbl[r].rdy);
            check($sformatf("tbl%0d_valid", r), o_valid, tbl[r].ev);
            check($sformatf("tbl%0d_ready", r), i_ready, 2'b11);
            if (tbl[r].ev) begin
                check($sformatf("tbl%0d_channel", r), o_channel, tbl[r].ech);
                check($sformatf("tbl%0d_array", r),   o_array,   tbl[r].earr);
                check($sformatf("tbl%0d_last", r),    o_last,    tbl[r].elast);
            end
        end

        // Continuous writes: frame starts are paced exactly by the interval.
        repeat (4) cycle('0, '0, 1'b1);
        for (int c = 0; c < 24; c++) begin
            cycle(2'b11, {$urandom(), $urandom()}, 1'b1);
            compare("interval");
            if (o_valid && o_channel == 1'b0) starts.push_back(c);
        end
        check("interval_frames", starts.size() >= 5, 1'b1);
        for (int i = 1; i < starts.size(); i++)
            check("interval_gap", starts[i] - starts[i-1], FI);

        // Reset while a beat is stalled aborts the frame for good.
        repeat (6) cycle('0, '0, 1'b1);
        cycle(2'b01, {32'h0, 32'h5A5A5A5A}, 1'b0);
        cycle('0, '0, 1'b0);
        compare("prereset");
        cycle('0, '0, 1'b0);
        compare("prereset_stall");
        #2 reset = 1'b1;
        #1 check("reset_async_valid", o_valid, 1'b0);
        @(posedge clk);
        #1;
        check("reset_next_valid", o_valid, 1'b0);
        check("reset_next_ready", i_ready, 2'b00);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            cycle('0, '0, 1'b1);
            check("no_beat_after_reset", o_valid, 1'b0);
        end
        cycle(2'b10, {32'hDEADBEEF, 32'h0}, 1'b1);
        compare("rewrite");
        cycle('0, '0, 1'b1);
        check("first_write_valid",   o_valid,   1'b1);
        check("first_write_channel", o_channel, 1'b0);
        check("first_write_array",   o_array,   32'h0);
        cycle('0, '0, 1'b1);
        check("first_write_ch1",  o_array, 32'hDEADBEEF);
        check("first_write_last", o_last,  1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [CH-1:0] iv;
            for (int k = 0; k < CH; k++) iv[k] = ($urandom_range(0, 9) < 3);
            cycle(iv, {$urandom(), $urandom()}, ($urandom_range(0, 3) != 0));
            compare("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
